// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per clock, LSB first, valid/ready on both sides.
// Optional macro SERIAL_ADD_SUB_SAT_EN replaces the sum with the signed saturation value on overflow.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N + 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_add_sub: DIGIT=%0d must divide WIDTH=%0d (WIDTH >= 2)", DIGIT, WIDTH);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             last_step;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] final_sum;
  logic             a_msb, b_msb, c_msb, ovf_now;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------- datapath
  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

  // New digit enters at the top; after N steps the LSB digit has reached bit 0.
  assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // On the last step the low digit of each shifter holds the operand MSB;
  // the carry into the MSB is recovered from a ^ b ^ sum at that bit.
  assign a_msb   = a_q[DIGIT-1];
  assign b_msb   = b_q[DIGIT-1];
  assign c_msb   = a_msb ^ b_msb ^ dsum[DIGIT-1];
  assign ovf_now = c_msb ^ dsum[DIGIT];

`ifdef SERIAL_ADD_SUB_SAT_EN
  always_comb begin
    final_sum = acc_next;
    if (ovf_now) final_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign final_sum = acc_next;
`endif

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept) begin
      a_d     = a;
      b_d     = sel ? ~b : b;
      carry_d = cin ^ sel;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      acc_d   = acc_next;
      carry_d = dsum[DIGIT];
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_step) begin
        sum_d  = final_sum;
        cout_d = dsum[DIGIT];
        ovf_d  = ovf_now;
        zero_d = (final_sum == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: WIDTH=8 instances with DIGIT=1 and DIGIT=4, directed plus random
// operations checked against an integer-arithmetic reference model.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin, sel;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0] sum1;
  logic       cout1, ovf1, zero1;

  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [7:0] sum4;
  logic       cout4, ovf4, zero4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sel(sel),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .sel(sel),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, what, obs, exp);
    end
  endtask

  // Reference: exact integer result, then wrap / detect overflow / saturate.
  function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                                input logic sl, output logic [7:0] s, output logic co,
                                output logic ov, output logic z);
    int ua, ub, sa, sb, c, us, ss;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    c  = ci ? 1 : 0;
    if (!sl) begin
      us = ua + ub + c;
      ss = sa + sb + c;
      co = (us > 255);
    end else begin
      us = ua - ub - c;
      ss = sa - sb - c;
      co = (us >= 0);
    end
    s  = us[7:0];
    ov = (ss > 127) || (ss < -128);
`ifdef SERIAL_ADD_SUB_SAT_EN
    if (ov) s = (ss > 0) ? 8'h7F : 8'h80;
`endif
    z = (s == 8'h00);
  endfunction

  function automatic logic [10:0] outs(input bit wide);
    return wide ? {out_valid4, in_ready4, sum4, cout4} : {out_valid1, in_ready1, sum1, cout1};
  endfunction

  task automatic run_op(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sl, input int hold, input string tag);
    logic [7:0] es;
    logic       eco, eov, ez;
    int         lat, n;
    model(av, bv, ci, sl, es, eco, eov, ez);
    n   = wide ? 2 : 8;
    a   = av; b = bv; cin = ci; sel = sl;
    if (wide) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    check(tag, "in_ready_idle", wide ? in_ready4 : in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sel = 1'($urandom);
    lat = 0;
    while (!(wide ? out_valid4 : out_valid1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, "latency", lat, n);
    check(tag, "sum",  wide ? sum4  : sum1,  es);
    check(tag, "cout", wide ? cout4 : cout1, eco);
    check(tag, "ovf",  wide ? ovf4  : ovf1,  eov);
    check(tag, "zero", wide ? zero4 : zero1, ez);
    for (int i = 0; i < hold; i++) begin
      if (wide) in_valid4 = 1'b1; else in_valid1 = 1'b1;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sel = 1'($urandom);
      @(posedge clk); #1;
      check(tag, "hold_outs", outs(wide), {1'b1, 1'b0, es, eco});
      check(tag, "hold_ovf_zero", wide ? {ovf4, zero4} : {ovf1, zero1}, {eov, ez});
    end
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    if (wide) out_ready4 = 1'b1; else out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    check(tag, "post_out_valid", wide ? out_valid4 : out_valid1, 0);
    check(tag, "post_in_ready",  wide ? in_ready4  : in_ready1,  1);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "outs", outs(1'b0), {1'b0, 1'b1, 8'h00, 1'b0});
    check("reset", "ovf_zero", {ovf1, zero1}, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 8'h05, 8'h03, 1'b1, 1'b0, 0, "add_5_3");

    // Result holds through IDLE until reset clears it.
    repeat (2) @(posedge clk);
    #1;
    check("idle_hold", "sum", sum1, 8'h09);
    rst = 1'b1; #1;
    check("reset_idle", "outs", outs(1'b0), {1'b0, 1'b1, 8'h00, 1'b0});
    check("reset_idle", "ovf_zero", {ovf1, zero1}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 0, "sub_5_7");
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, "add_ff_1");
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, "ovf_pos");
    run_op(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 5, "ovf_neg_bp");
    run_op(1'b1, 8'h9C, 8'h64, 1'b0, 1'b0, 0, "d4_add");
    run_op(1'b1, 8'h80, 8'h7F, 1'b1, 1'b1, 2, "d4_sub");

    // Reset in the middle of an operation: no result may ever appear.
    a = 8'h12; b = 8'h34; cin = 1'b0; sel = 1'b0;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    check("reset_run", "outs", outs(1'b0), {1'b0, 1'b1, 8'h00, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid1) seen++;
    end
    check("reset_run", "no_out_valid", seen, 0);

    for (int i = 0; i < 20; i++)
      run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), $sformatf("rnd1_%0d", i));
    for (int i = 0; i < 12; i++)
      run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), $sformatf("rnd4_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
